// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 DMA bus arbiter.
// Holds the FSM encoding, the idle strobe pattern and a width helper.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAITAK,
        SETUP,
        STROBE,
        DONE,
        RELEASE
    } state_t;

    // {mreq_n, rd_n, wr_n} with nothing asserted
    localparam logic [2:0] STROBE_IDLE = 3'b111;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/z80_dma_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; the arbiter shares one instance between grant paths.
module rr_pick
    import z80_bus_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int PW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            vld
);

    logic [NREQ-1:0] rot;
    int              s;

    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        s   = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!vld && rot[i]) begin
                vld = 1'b1;
                s   = int'(ptr) + i;
                if (s >= NREQ) s = s - NREQ;
                idx = PW'(s);
            end
        end
        if (vld) gnt = NREQ'(1) << idx;
    end

endmodule

// File: rtl/z80_dma_bus_arbiter.sv
// Borrows the Z80 bus via busrq_n/busak_n and runs single-byte
// transfers for NREQ requesters in round-robin order.
module z80_dma_bus_arbiter
    import z80_bus_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ACC_CYC   = 3,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*16-1:0] req_addr,
    input  logic [NREQ*8-1:0]  req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic [7:0]         rdata,
    output logic               busrq_n,
    input  logic               busak_n,
    output logic               bus_own,
    output logic [15:0]        A,
    output logic [7:0]         dout,
    input  logic [7:0]         di,
    output logic               mreq_n,
    output logic               rd_n,
    output logic               wr_n
);

    localparam int PW = idx_w(NREQ);
    localparam int CW = idx_w(ACC_CYC);
    localparam int BW = idx_w(MAX_BURST);
    localparam logic [CW-1:0] ACC_LAST = CW'(ACC_CYC - 1);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   nxt_ptr;
    logic [PW-1:0]   pick_ptr;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] sel_oh;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_vld;
    logic            more;
    logic [CW-1:0]   acc_cnt;
    logic [BW-1:0]   burst_cnt;
    logic [15:0]     pick_addr;
    logic [7:0]      pick_wdata;

    assign sel_oh  = NREQ'(1) << sel;
    assign nxt_ptr = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
    assign more    = (int'(burst_cnt) + 1) < MAX_BURST;

    // After a transfer the just-served requester is masked and the
    // search restarts behind it, so it yields to everyone else.
    assign pick_req = (state == DONE) ? (req & ~sel_oh) : req;
    assign pick_ptr = (state == DONE) ? nxt_ptr : ptr;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_addr  = pick_addr | req_addr[16*i +: 16];
                pick_wdata = pick_wdata | req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                <= IDLE;
            ptr                  <= '0;
            sel                  <= '0;
            acc_cnt              <= '0;
            burst_cnt            <= '0;
            ack                  <= '0;
            rdata                <= '0;
            busrq_n              <= 1'b1;
            bus_own              <= 1'b0;
            A                    <= '0;
            dout                 <= '0;
            {mreq_n, rd_n, wr_n} <= STROBE_IDLE;
        end else begin
            ack <= '0;
            // CPU took the bus back while we held it: drop everything
            if (bus_own && busak_n) begin
                {mreq_n, rd_n, wr_n} <= STROBE_IDLE;
                bus_own              <= 1'b0;
                busrq_n              <= 1'b1;
                burst_cnt            <= '0;
                state                <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (|req) begin
                            busrq_n <= 1'b0;
                            state   <= WAITAK;
                        end
                    end
                    WAITAK: begin
                        if (!busak_n) begin
                            if (pick_vld) begin
                                sel     <= pick_idx;
                                A       <= pick_addr;
                                dout    <= pick_wdata;
                                bus_own <= 1'b1;
                                state   <= SETUP;
                            end else begin
                                busrq_n <= 1'b1;
                                state   <= RELEASE;
                            end
                        end
                    end
                    SETUP: begin
                        mreq_n  <= 1'b0;
                        rd_n    <= req_we[sel];
                        wr_n    <= ~req_we[sel];
                        acc_cnt <= '0;
                        state   <= STROBE;
                    end
                    STROBE: begin
                        if (acc_cnt == ACC_LAST) begin
                            if (!rd_n) rdata <= di;
                            {mreq_n, rd_n, wr_n} <= STROBE_IDLE;
                            ack   <= sel_oh;
                            state <= DONE;
                        end else begin
                            acc_cnt <= acc_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        ptr <= nxt_ptr;
                        if (pick_vld && more) begin
                            burst_cnt <= burst_cnt + 1'b1;
                            sel       <= pick_idx;
                            A         <= pick_addr;
                            dout      <= pick_wdata;
                            state     <= SETUP;
                        end else begin
                            bus_own   <= 1'b0;
                            busrq_n   <= 1'b1;
                            burst_cnt <= '0;
                            state     <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (busak_n) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z80_dma_bus_arbiter.sv
// Bench for z80_dma_bus_arbiter: directed steps plus random traffic
// checked against a queue-based requester/memory model.
module tb_z80_dma_bus_arbiter;

    localparam int NREQ      = 2;
    localparam int ACC_CYC   = 3;
    localparam int MAX_BURST = 4;

    typedef struct {
        int          idx;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } xfer_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*16-1:0] req_addr;
    logic [NREQ*8-1:0]  req_wdata;
    logic [NREQ-1:0]    ack;
    logic [7:0]         rdata;
    logic               busrq_n;
    logic               busak_n;
    logic               bus_own;
    logic [15:0]        A;
    logic [7:0]         dout;
    logic [7:0]         di;
    logic               mreq_n;
    logic               rd_n;
    logic               wr_n;

    always #5 clk = ~clk;

    z80_dma_bus_arbiter #(
        .NREQ(NREQ), .ACC_CYC(ACC_CYC), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata),
        .busrq_n(busrq_n), .busak_n(busak_n), .bus_own(bus_own),
        .A(A), .dout(dout), .di(di),
        .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int m_ptr = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int strobe_len = 0;
    int strobe_start = 0;
    int tenure_acks = 0;
    int max_tenure = 0;
    int rq_falls = 0;
    int ak_cnt = 0;
    int rel_cnt = 0;
    bit cpu_manual = 1'b1;
    bit aborting = 1'b0;
    bit strobe_wr = 1'b0;
    logic prev_busrq_n = 1'b1;
    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    xfer_t pend[$];
    int ack_log[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int head_of(input int i);
        foreach (pend[k]) if (pend[k].idx == i) return k;
        return -1;
    endfunction

    // Spec rule: first requester with work at or after the pointer
    function automatic int exp_next();
        for (int n = 0; n < NREQ; n++) begin
            int i;
            i = (m_ptr + n) % NREQ;
            if (head_of(i) >= 0) return i;
        end
        return -1;
    endfunction

    task automatic apply_req(input int i);
        int k;
        k = head_of(i);
        if (k < 0) begin
            req[i]    = 1'b0;
            req_we[i] = 1'b0;
        end else begin
            req[i]                 = 1'b1;
            req_we[i]              = pend[k].we;
            req_addr[16*i +: 16]   = pend[k].addr;
            req_wdata[8*i +: 8]    = pend[k].wdata;
        end
    endtask

    task automatic push(input int i, input bit we, input logic [15:0] a,
                        input logic [7:0] d);
        xfer_t x;
        x.idx = i; x.we = we; x.addr = a; x.wdata = d;
        pend.push_back(x);
        apply_req(i);
    endtask

    task automatic handle_ack();
        int idx;
        int k;
        xfer_t x;
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
        chk("ack_onehot", 32'($countones(ack)), 1);
        chk("ack_order", idx, exp_next());
        k = head_of(idx);
        chk("ack_pending", 32'(k >= 0), 1);
        if (k >= 0) begin
            x = pend[k];
            chk("ack_addr", 32'(A), 32'(x.addr));
            chk("ack_dir", 32'(strobe_wr), 32'(x.we));
            if (x.we) begin
                chk("wr_dout", 32'(dout), 32'(x.wdata));
                chk("wr_mem", 32'(mem[x.addr]), 32'(x.wdata));
                ref_mem[x.addr] = x.wdata;
            end else begin
                chk("rd_data", 32'(rdata), 32'(ref_mem[x.addr]));
            end
            pend.delete(k);
            apply_req(idx);
            m_ptr = (idx + 1) % NREQ;
        end
        ack_cnt++;
        ack_cyc = cyc;
        ack_log.push_back(idx);
        tenure_acks++;
        if (tenure_acks > max_tenure) max_tenure = tenure_acks;
        chk("burst_limit", 32'(tenure_acks <= MAX_BURST), 1);
    endtask

    task automatic cpu_step();
        if (cpu_manual) return;
        if (!busrq_n && busak_n) begin
            if (ak_cnt == 0) begin
                busak_n = 1'b0;
                ak_cnt  = $urandom_range(0, 3);
            end else ak_cnt--;
        end else if (busrq_n && !busak_n) begin
            if (rel_cnt == 0) begin
                busak_n = 1'b1;
                rel_cnt = $urandom_range(0, 2);
            end else rel_cnt--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_own && !mreq_n && !wr_n) mem[A] = dout;
        di = mem[A];
        if (!bus_own) chk("released_strobes", 32'({mreq_n, rd_n, wr_n}), 32'h7);
        if (!mreq_n) begin
            if (strobe_len == 0) begin
                strobe_start = cyc;
                strobe_wr    = 1'b0;
            end
            strobe_len++;
            if (!wr_n) strobe_wr = 1'b1;
            chk("rw_excl", 32'(rd_n ^ wr_n), 1);
        end else if (strobe_len != 0) begin
            if (aborting) aborting = 1'b0;
            else chk("strobe_len", strobe_len, ACC_CYC);
            strobe_len = 0;
        end
        if (!busrq_n && prev_busrq_n) rq_falls++;
        prev_busrq_n = busrq_n;
        if (busak_n) tenure_acks = 0;
        if (ack != '0) handle_ack();
        cpu_step();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            tick();
            n++;
            ok = (pend.size() == 0) && busrq_n && busak_n && !bus_own;
        end
        chk({"idle_", tag}, 32'(ok), 1);
    endtask

    task automatic wait_rq(input string tag);
        int n;
        n = 0;
        while (busrq_n && n < 10) begin tick(); n++; end
        chk({"busrq_", tag}, 32'(busrq_n), 0);
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (mreq_n && n < 10) begin tick(); n++; end
        chk({"strobe_", tag}, 32'(mreq_n), 0);
    endtask

    initial begin
        int t0;
        int base;
        reset_n   = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        busak_n   = 1'b1;
        di        = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset values
        tick(); tick();
        chk("rst_busrq_n", 32'(busrq_n), 1);
        chk("rst_bus_own", 32'(bus_own), 0);
        chk("rst_strobes", 32'({mreq_n, rd_n, wr_n}), 32'h7);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_A", 32'(A), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_rdata", 32'(rdata), 0);
        reset_n = 1'b1;
        tick();

        // Single read with exact latency
        mem[16'hC000]     = 8'h5A;
        ref_mem[16'hC000] = 8'h5A;
        push(0, 1'b0, 16'hC000, 8'h00);
        tick();
        chk("t1_busrq_lat", 32'(busrq_n), 0);
        tick(); tick(); tick();
        busak_n = 1'b0;
        t0 = cyc;
        base = ack_cnt;
        for (int n = 0; n < 20 && ack_cnt == base; n++) tick();
        chk("t1_ack_seen", ack_cnt, base + 1);
        chk("t1_strobe_start", strobe_start, t0 + 2);
        chk("t1_ack_lat", ack_cyc, t0 + 2 + ACC_CYC);
        chk("t1_rdata", 32'(rdata), 32'h5A);
        tick();
        chk("t1_busrq_rel", 32'(busrq_n), 1);
        chk("t1_bus_own", 32'(bus_own), 0);
        busak_n = 1'b1;
        tick(); tick();

        // Single write on requester 1
        cpu_manual = 1'b0;
        base = ack_cnt;
        push(1, 1'b1, 16'h8001, 8'hA5);
        wait_idle("t2", 100);
        chk("t2_acks", ack_cnt, base + 1);
        chk("t2_mem", 32'(mem[16'h8001]), 32'hA5);
        chk("t2_rdata_held", 32'(rdata), 32'h5A);

        // Both requesters saturated: alternate, four per tenure
        base = ack_cnt;
        rq_falls = 0;
        max_tenure = 0;
        for (int n = 0; n < 4; n++) begin
            push(0, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
            push(1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
        end
        wait_idle("t3", 400);
        chk("t3_count", ack_cnt, base + 8);
        for (int n = 0; n < 8; n++)
            if (base + n < ack_log.size())
                chk("t3_order", ack_log[base + n], n % 2);
        chk("t3_max_tenure", max_tenure, MAX_BURST);
        chk("t3_tenures", rq_falls, 2);

        // Random traffic on a small window so reads see earlier writes
        for (int r = 0; r < 10; r++) begin
            int cnt;
            cnt = $urandom_range(1, 6);
            base = ack_cnt;
            for (int j = 0; j < cnt; j++)
                push($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)),
                     {8'hC0, 4'h0, 4'($urandom_range(0, 15))}, 8'($urandom));
            wait_idle("rand", 600);
            chk("rand_count", ack_cnt, base + cnt);
        end

        // CPU pulls busak_n back mid-strobe
        cpu_manual = 1'b1;
        base = ack_cnt;
        push(0, 1'b0, 16'hC003, 8'h00);
        wait_rq("t5a");
        busak_n = 1'b0;
        wait_strobe("t5");
        tick();
        busak_n  = 1'b1;
        aborting = 1'b1;
        tick();
        chk("t5_strobes", 32'({mreq_n, rd_n, wr_n}), 32'h7);
        chk("t5_bus_own", 32'(bus_own), 0);
        chk("t5_no_ack", ack_cnt, base);
        tick();
        chk("t5_retry_rq", 32'(busrq_n), 0);
        cpu_manual = 1'b0;
        ak_cnt = 1;
        wait_idle("t5", 100);
        chk("t5_retried", ack_cnt, base + 1);

        // Reset in the middle of a strobe
        cpu_manual = 1'b1;
        push(1, 1'b0, 16'hC00F, 8'h00);
        wait_rq("t6");
        busak_n = 1'b0;
        wait_strobe("t6");
        tick();
        reset_n  = 1'b0;
        aborting = 1'b1;
        base = ack_cnt;
        tick();
        chk("t6_busrq_n", 32'(busrq_n), 1);
        chk("t6_bus_own", 32'(bus_own), 0);
        chk("t6_strobes", 32'({mreq_n, rd_n, wr_n}), 32'h7);
        chk("t6_A", 32'(A), 0);
        chk("t6_rdata", 32'(rdata), 0);
        pend.delete();
        req = '0;
        m_ptr = 0;
        reset_n = 1'b1;
        busak_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("t6_quiet", 32'({mreq_n, busrq_n}), 32'h3);
        end
        chk("t6_no_ack", ack_cnt, base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
